// File: rtl/sdram_fill_pkg.sv
// sdram_fill_pkg
//   Shared definitions for the SDRAM fill master: FSM state encoding,
//   the 16-bit Galois LFSR polynomial, the default seed and a one-step
//   LFSR helper used by the lfsr16 sub-module.
package sdram_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fill_state_t;

  localparam logic [15:0] LFSR_POLY    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Right-shifting Galois step: the bit shifted out selects the feedback taps.
  function automatic logic [15:0] lfsr_step(input logic [15:0] value);
    return (value >> 1) ^ (value[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sdram_fill_master_lfsr16.sv
// lfsr16
//   16-bit Galois LFSR register.
//   Ports:
//     clk    in   clock
//     reset  in   synchronous active-high reset, loads seed
//     load   in   load seed (priority over step)
//     seed   in   16-bit load value
//     step   in   advance one LFSR step
//     q      out  current LFSR value (registered)
module lfsr16
  import sdram_fill_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= seed;
    end else if (load) begin
      q_reg <= seed;
    end else if (step) begin
      q_reg <= lfsr_step(q_reg);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/sdram_fill_master.sv
// sdram_fill_master
//   Avalon-MM write master that fills NUM_WORDS consecutive SDRAM words,
//   starting at BASE_ADDR, with 16-bit LFSR data, then raises done. The
//   min/max of the written words are kept so a downstream reader's results
//   can be checked on-board.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     start                 begin a fill (sampled in IDLE or DONE)
//     waitrequest           Avalon slave stall
//     read_n, chipselect    constant 1
//     write_n               write strobe, active-low
//     address               word address
//     byteenable            constant 2'b11
//     writedata             current LFSR word
//     done, busy            DONE / WRITE state flags
//     exp_min, exp_max      min / max of words accepted this fill
//     word_count            words accepted this fill
module sdram_fill_master
  import sdram_fill_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          NUM_WORDS = 10,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        waitrequest,
  output logic        read_n,
  output logic        write_n,
  output logic        chipselect,
  output logic [31:0] address,
  output logic [1:0]  byteenable,
  output logic [15:0] writedata,
  output logic        done,
  output logic        busy,
  output logic [15:0] exp_min,
  output logic [15:0] exp_max,
  output logic [15:0] word_count
);

  localparam logic [15:0] LAST_COUNT = 16'(NUM_WORDS - 1);

  fill_state_t state_reg, state_next;
  logic        write_n_reg, write_n_next;
  logic        done_reg, done_next;
  logic        busy_reg, busy_next;
  logic [31:0] address_reg;
  logic [15:0] word_count_reg;
  logic [15:0] exp_min_reg;
  logic [15:0] exp_max_reg;
  logic [15:0] lfsr_q;

  logic fill_start;
  logic accept;
  logic last_accept;

  // write_n is low for the whole WRITE state, so acceptance only needs
  // the state and the slave's stall.
  assign fill_start  = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign accept      = (state_reg == WRITE) && !waitrequest;
  assign last_accept = accept && (word_count_reg == LAST_COUNT);

  // State and strobe/flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      write_n_reg <= 1'b1;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      write_n_reg <= write_n_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = WRITE;
      WRITE:   if (last_accept) state_next = DONE;
      DONE:    if (start) state_next = WRITE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: flags are decoded from the next state and registered,
  // so every output comes straight from a flop.
  always_comb begin
    write_n_next = (state_next != WRITE);
    busy_next    = (state_next == WRITE);
    done_next    = (state_next == DONE);
  end

  // Address, counter and running min/max
  always_ff @(posedge clk) begin
    if (reset || fill_start) begin
      address_reg    <= BASE_ADDR;
      word_count_reg <= 16'h0000;
      exp_min_reg    <= 16'hFFFF;
      exp_max_reg    <= 16'h0000;
    end else if (accept) begin
      address_reg    <= address_reg + 32'd1;
      word_count_reg <= word_count_reg + 16'd1;
      if (lfsr_q < exp_min_reg) exp_min_reg <= lfsr_q;
      if (lfsr_q > exp_max_reg) exp_max_reg <= lfsr_q;
    end
  end

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (fill_start),
    .seed  (LFSR_SEED),
    .step  (accept),
    .q     (lfsr_q)
  );

  assign read_n     = 1'b1;
  assign chipselect = 1'b1;
  assign byteenable = 2'b11;
  assign write_n    = write_n_reg;
  assign done       = done_reg;
  assign busy       = busy_reg;
  assign address    = address_reg;
  assign writedata  = lfsr_q;
  assign exp_min    = exp_min_reg;
  assign exp_max    = exp_max_reg;
  assign word_count = word_count_reg;

endmodule

// File: tb/tb_sdram_fill_master.sv
// tb_sdram_fill_master
//   Two instances: A with default parameters (10 words), B with NUM_WORDS=1.
//   A word-level reference model is compared against every output on every
//   falling edge; directed scenarios add literal expectations on top.
module tb_sdram_fill_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset   = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic wr_a    = 1'b0;
  logic wr_b    = 1'b0;

  logic        a_read_n, a_write_n, a_cs, a_done, a_busy;
  logic [31:0] a_address;
  logic [1:0]  a_be;
  logic [15:0] a_wdata, a_min, a_max, a_wc;
  logic        b_read_n, b_write_n, b_cs, b_done, b_busy;
  logic [31:0] b_address;
  logic [1:0]  b_be;
  logic [15:0] b_wdata, b_min, b_max, b_wc;

  sdram_fill_master dut_a (
    .clk(clk), .reset(reset), .start(start_a), .waitrequest(wr_a),
    .read_n(a_read_n), .write_n(a_write_n), .chipselect(a_cs),
    .address(a_address), .byteenable(a_be), .writedata(a_wdata),
    .done(a_done), .busy(a_busy), .exp_min(a_min), .exp_max(a_max),
    .word_count(a_wc)
  );

  sdram_fill_master #(.NUM_WORDS(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .waitrequest(wr_b),
    .read_n(b_read_n), .write_n(b_write_n), .chipselect(b_cs),
    .address(b_address), .byteenable(b_be), .writedata(b_wdata),
    .done(b_done), .busy(b_busy), .exp_min(b_min), .exp_max(b_max),
    .word_count(b_wc)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    else pass_cnt++;
  endtask

  // ---------------- reference model ----------------
  logic [15:0] seq [0:15];
  logic        m_active [2];
  logic        m_done   [2];
  int          m_idx    [2];
  logic [31:0] log_q [$];
  int          rise_a = -1;
  int          rise_b = -1;
  logic        prev_a_done = 1'b0;
  logic        prev_b_done = 1'b0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int words_of(input int d);
    return (d == 0) ? 10 : 1;
  endfunction

  initial begin
    seq[0] = 16'hACE1;
    for (int i = 1; i < 16; i++) seq[i] = lfsr_next(seq[i-1]);
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0;
      m_done[d]   = 1'b0;
      m_idx[d]    = 0;
    end
  end

  always @(posedge clk) begin
    logic st, wq;
    cyc++;
    if (!reset && !a_write_n && !wr_a) log_q.push_back({a_address[15:0], a_wdata});
    for (int d = 0; d < 2; d++) begin
      st = (d == 0) ? start_a : start_b;
      wq = (d == 0) ? wr_a : wr_b;
      if (reset) begin
        m_active[d] = 1'b0;
        m_done[d]   = 1'b0;
        m_idx[d]    = 0;
      end else if (!m_active[d] && st) begin
        m_active[d] = 1'b1;
        m_done[d]   = 1'b0;
        m_idx[d]    = 0;
      end else if (m_active[d] && !wq) begin
        m_idx[d]++;
        if (m_idx[d] == words_of(d)) begin
          m_active[d] = 1'b0;
          m_done[d]   = 1'b1;
        end
      end
    end
  end

  task automatic cmp_dut(input int d, input string p,
                         input logic rn, input logic wn, input logic cs,
                         input logic [31:0] ad, input logic [1:0] be,
                         input logic [15:0] wd, input logic dn, input logic by,
                         input logic [15:0] mn, input logic [15:0] mx,
                         input logic [15:0] wc);
    logic [15:0] emin, emax;
    emin = 16'hFFFF;
    emax = 16'h0000;
    for (int i = 0; i < m_idx[d]; i++) begin
      if (seq[i] < emin) emin = seq[i];
      if (seq[i] > emax) emax = seq[i];
    end
    chk({p, ".read_n"},     32'(rn), 32'd1);
    chk({p, ".chipselect"}, 32'(cs), 32'd1);
    chk({p, ".byteenable"}, 32'(be), 32'd3);
    chk({p, ".write_n"},    32'(wn), 32'(!m_active[d]));
    chk({p, ".busy"},       32'(by), 32'(m_active[d]));
    chk({p, ".done"},       32'(dn), 32'(m_done[d]));
    chk({p, ".address"},    ad,      32'(m_idx[d]));
    chk({p, ".writedata"},  32'(wd), 32'(seq[m_idx[d]]));
    chk({p, ".word_count"}, 32'(wc), 32'(m_idx[d]));
    chk({p, ".exp_min"},    32'(mn), 32'(emin));
    chk({p, ".exp_max"},    32'(mx), 32'(emax));
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      cmp_dut(0, "A", a_read_n, a_write_n, a_cs, a_address, a_be, a_wdata,
              a_done, a_busy, a_min, a_max, a_wc);
      cmp_dut(1, "B", b_read_n, b_write_n, b_cs, b_address, b_be, b_wdata,
              b_done, b_busy, b_min, b_max, b_wc);
    end
    if (a_done && !prev_a_done) rise_a = cyc;
    if (b_done && !prev_b_done) rise_b = cyc;
    prev_a_done = a_done;
    prev_b_done = b_done;
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] tab [0:9];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int d, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if ((d == 0 ? a_done : b_done) == 1'b1) break;
      tick(1);
    end
    chk({tag, "_done_reached"}, 32'(d == 0 ? a_done : b_done), 32'd1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_log_size"}, 32'(log_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < log_q.size(); i++)
      chk($sformatf("%s_write%0d", tag, i), log_q[i], {16'(i), tab[i]});
  endtask

  int s;

  initial begin
    tab[0] = 16'hACE1; tab[1] = 16'hE270; tab[2] = 16'h7138; tab[3] = 16'h389C;
    tab[4] = 16'h1C4E; tab[5] = 16'h0E27; tab[6] = 16'hB313; tab[7] = 16'hED89;
    tab[8] = 16'hC2C4; tab[9] = 16'h6162;
    #1;
    for (int i = 0; i < 10; i++) chk($sformatf("model_seq%0d", i), 32'(seq[i]), 32'(tab[i]));

    // Reset state
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_write_n", 32'(a_write_n), 32'd1);
    chk("rst_address", a_address, 32'h0);
    chk("rst_writedata", 32'(a_wdata), 32'hACE1);
    chk("rst_exp_min", 32'(a_min), 32'hFFFF);
    chk("rst_exp_max", 32'(a_max), 32'h0000);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_word_count", 32'(a_wc), 32'd0);

    // 1: plain fill, one-cycle start pulse
    log_q.delete();
    rise_a = -1;
    start_a = 1'b1; s = cyc;
    tick(1);
    start_a = 1'b0;
    wait_done(0, 40, "t1");
    @(negedge clk); #1;
    chk("t1_latency", 32'(rise_a - s), 32'd11);
    chk("t1_exp_min", 32'(a_min), 32'h0E27);
    chk("t1_exp_max", 32'(a_max), 32'hED89);
    chk("t1_word_count", 32'(a_wc), 32'd10);
    chk("t1_address", a_address, 32'd10);
    check_log("t1");

    // 2: restart from DONE with a 3-cycle stall on word 3
    tick(2);
    log_q.delete();
    rise_a = -1;
    start_a = 1'b1; s = cyc;
    tick(1);
    start_a = 1'b0;
    chk("t2_done_drop", 32'(a_done), 32'd0);
    chk("t2_busy", 32'(a_busy), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (a_address == 32'd3) break;
      tick(1);
    end
    chk("t2_reach_addr3", a_address, 32'd3);
    wr_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t2_stall_addr", a_address, 32'd3);
      chk("t2_stall_data", 32'(a_wdata), 32'h389C);
      chk("t2_stall_write_n", 32'(a_write_n), 32'd0);
    end
    wr_a = 1'b0;
    wait_done(0, 40, "t2");
    @(negedge clk); #1;
    chk("t2_latency", 32'(rise_a - s), 32'd14);
    chk("t2_exp_min", 32'(a_min), 32'h0E27);
    chk("t2_exp_max", 32'(a_max), 32'hED89);
    chk("t2_word_count", 32'(a_wc), 32'd10);
    check_log("t2");

    // 3: reset in the middle of a fill
    tick(1);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (a_wc == 16'd5) break;
      tick(1);
    end
    chk("t3_reach_wc5", 32'(a_wc), 32'd5);
    reset = 1'b1;
    tick(1);
    chk("t3_write_n", 32'(a_write_n), 32'd1);
    chk("t3_busy", 32'(a_busy), 32'd0);
    chk("t3_done", 32'(a_done), 32'd0);
    chk("t3_exp_min", 32'(a_min), 32'hFFFF);
    chk("t3_exp_max", 32'(a_max), 32'h0000);
    chk("t3_word_count", 32'(a_wc), 32'd0);
    chk("t3_address", a_address, 32'd0);
    reset = 1'b0;
    tick(2);
    chk("t3_stays_idle", 32'(a_write_n), 32'd1);

    // 4: start held high through the whole fill
    log_q.delete();
    rise_a = -1;
    start_a = 1'b1; s = cyc;
    wait_done(0, 40, "t4");
    chk("t4_accepts", 32'(log_q.size()), 32'd10);
    @(negedge clk); #1;
    chk("t4_latency", 32'(rise_a - s), 32'd11);
    tick(1);
    chk("t4_refill_busy", 32'(a_busy), 32'd1);
    chk("t4_refill_done", 32'(a_done), 32'd0);
    chk("t4_refill_addr", a_address, 32'd0);
    start_a = 1'b0;
    wait_done(0, 40, "t4b");

    // 5: NUM_WORDS=1 instance
    rise_b = -1;
    start_b = 1'b1; s = cyc;
    tick(1);
    start_b = 1'b0;
    wait_done(1, 20, "t5");
    @(negedge clk); #1;
    chk("t5_latency", 32'(rise_b - s), 32'd2);
    chk("t5_exp_min", 32'(b_min), 32'hACE1);
    chk("t5_exp_max", 32'(b_max), 32'hACE1);
    chk("t5_address", b_address, 32'd1);
    chk("t5_word_count", 32'(b_wc), 32'd1);
    chk("t5_writedata", 32'(b_wdata), 32'hE270);

    tick(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
